lift_scheduler: RTL and testbench
=================================

Name: lift_scheduler

Overview:
Request scheduler that sequences the lift car. It latches floor call requests from the hall and cab buttons, picks the next target with a SCAN policy (keep direction while calls are pending ahead, then reverse), models travel and door dwell time, and reports the car position and status. It sits in front of the `lift` block and supplies its floor input and status signals.

Parameters:
NUM_FLOORS, 4, number of floors, floor 0 is the bottom.
FLOOR_W, 2, width of the floor index; requires 2**FLOOR_W >= NUM_FLOORS.
TRAVEL_CYCLES, 4, clock cycles to move one floor; minimum 1.
DOOR_CYCLES, 6, clock cycles the door stays open per stop; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, synchronous, active-high.
call_req  input  NUM_FLOORS  one bit per floor; a 1 in any cycle registers a call for that floor.
pending  output  NUM_FLOORS  registered outstanding calls.
cur_floor  output  FLOOR_W  current car floor.
dir  output  2  00 idle, 01 up, 10 down; 11 is never driven.
moving  output  1  high while in MOVE.
door_open  output  1  high while in DOOR.
arrive  output  1  one-cycle pulse in the cycle cur_floor takes a new value.

Behaviour:
- Reset (rst high at an edge, from any state, including mid-MOVE or mid-DOOR): state IDLE, pending=0, cur_floor=0, dir=00, moving=0, door_open=0, arrive=0, timer=0. A call_req seen in the same cycle as rst is discarded.
- Call capture: each edge, pending <= pending | call_req, except where a bit is cleared below. Clear wins over set for the same bit in the same cycle.
- Decisions use only the registered pending and never the raw call_req. "Ahead up" means any pending bit above cur_floor; "ahead down" means any pending bit below it.
- States:
  - IDLE: dir=00.
    - pending[cur_floor]=1: go to DOOR and clear that bit.
    - Otherwise, any pending above: go to MOVE with dir=01.
    - Otherwise, any pending below: go to MOVE with dir=10.
    - When both above and below are pending, up wins.
    - Otherwise stay in IDLE.
  - MOVE:
    - The timer counts 0..TRAVEL_CYCLES-1.
    - At the edge where timer==TRAVEL_CYCLES-1, cur_floor steps by +1 or -1, arrive goes to 1 for one cycle, and the timer goes to 0.
    - In the same edge, evaluate the new floor f:
      - pending[f]=1: go to DOOR and clear pending[f].
      - Otherwise, pending ahead in dir: stay in MOVE.
      - Otherwise: go to IDLE.
  - DOOR:
    - The timer counts 0..DOOR_CYCLES-1, so door_open is high for exactly DOOR_CYCLES cycles.
    - call_req[cur_floor] during DOOR is absorbed: the bit is not set and the timer restarts at 0.
    - At the edge where timer==DOOR_CYCLES-1:
      - Pending ahead in current dir: go to MOVE, same dir.
      - Otherwise, pending in the opposite direction: go to MOVE with dir reversed.
      - Otherwise: go to IDLE with dir=00.
      - If dir was 00 on entry, use the IDLE rule: up before down.
- Bounds: cur_floor never leaves 0..NUM_FLOORS-1. It cannot step past an end because a move only continues while a call is pending ahead.
- Latency: call_req pulsed in cycle t while IDLE with a call elsewhere gives pending set from t+1, moving=1 from t+2, and the first arrive at t+1+TRAVEL_CYCLES+1.
- All outputs are registered.

Test Plan:
- Reset: hold rst for 2 cycles with call_req=4'b1111 -> pending=0000, cur_floor=0, dir=00, moving=0, door_open=0; once rst is released, no move starts.
- Single long trip: at floor 0 in IDLE, pulse call_req=4'b1000 for one cycle.
  - Expect pending=1000, then MOVE with dir=01.
  - cur_floor goes 1, 2, 3 at 4-cycle spacing, with an arrive pulse at each step.
  - Expect door_open for 6 cycles, pending=0000 on arrival at floor 3, then IDLE with dir=00.
- Call at current floor while idle: with cur_floor=0, pulse call_req=4'b0001 -> door_open for 6 cycles, cur_floor stays 0, no arrive pulse.
- SCAN order: while moving up from 0 toward 3, pulse 4'b0100 while still below floor 2, and 4'b0001 later.
  - Expect stops, in order, at 2, 3, then 0.
  - dir goes 01 then 10; each stop has 6 door cycles.
- Tie and absorb:
  - Idle at floor 1 with pending=1001 -> moves up first, stops at 3, then goes down to 0.
  - While the door is open at 3, pulse call_req=4'b1000 -> pending[3] stays 0 and the door stays open 6 cycles from that pulse.
- Reset mid-MOVE: assert rst 2 cycles after leaving floor 1 -> next cycle cur_floor=0, dir=00, pending=0000, moving=0.

Source files
------------

// File: rtl/lift_scheduler.sv
// SCAN-policy lift request scheduler: latches floor calls, sequences travel and
// door dwell, and reports car position and status as registered outputs.
module lift_scheduler #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [1:0]            dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, step_floor;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    arrive_q, arrive_d;
  logic                    moving_q, door_q;
  logic                    above, below;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
    logic hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && (i > int'(f))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
    logic hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && (i < int'(f))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f, input dir_e d);
    return (d == DIR_UP) ? any_above(p, f) :
           (d == DIR_DOWN) ? any_below(p, f) : 1'b0;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    dir_d      = dir_q;
    pending_d  = pending_q | call_req;
    floor_d    = floor_q;
    timer_d    = timer_q;
    arrive_d   = 1'b0;
    above      = any_above(pending_q, floor_q);
    below      = any_below(pending_q, floor_q);
    step_floor = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pending_q[floor_q]) begin
          state_d            = S_DOOR;
          pending_d[floor_q] = 1'b0;
        end else if (above) begin
          state_d = S_MOVE;
          dir_d   = DIR_UP;
        end else if (below) begin
          state_d = S_MOVE;
          dir_d   = DIR_DOWN;
        end
      end
      S_MOVE: begin
        if (timer_q == TRAVEL_LAST) begin
          floor_d  = step_floor;
          arrive_d = 1'b1;
          timer_d  = '0;
          if (pending_q[step_floor]) begin
            state_d               = S_DOOR;
            pending_d[step_floor] = 1'b0;
          end else if (!any_ahead(pending_q, step_floor, dir_q)) begin
            state_d = S_IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DOOR: begin
        // A call for the floor whose door is open is absorbed and re-arms the dwell.
        pending_d[floor_q] = 1'b0;
        if (call_req[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = S_MOVE;
          if (dir_q != DIR_DOWN && above)      dir_d = DIR_UP;
          else if (below)                      dir_d = DIR_DOWN;
          else if (above)                      dir_d = DIR_UP;
          else begin
            state_d = S_IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_IDLE;
      pending_q <= '0;
      floor_q   <= '0;
      timer_q   <= '0;
      arrive_q  <= 1'b0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      floor_q   <= floor_d;
      timer_q   <= timer_d;
      arrive_q  <= arrive_d;
      moving_q  <= (state_d == S_MOVE);
      door_q    <= (state_d == S_DOOR);
    end
  end

  assign pending   = pending_q;
  assign cur_floor = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign arrive    = arrive_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// Self-checking bench for lift_scheduler: a floor-level reference model queues
// expected status snapshots; a monitor compares them at each DUT status event.
module tb_lift_scheduler;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic [NF-1:0] pending;
  logic [FW-1:0] cur_floor;
  logic [1:0]    dir;
  logic          moving, door_open, arrive;

  lift_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .pending(pending),
    .cur_floor(cur_floor), .dir(dir), .moving(moving),
    .door_open(door_open), .arrive(arrive)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NF-1:0] pend;
    int            floor;
    logic [1:0]    dir;
    logic          moving;
    logic          door;
    logic          arrive;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_events = 0;
  int cycle    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: car position as an integer, direction as +1/-1/0, mode 0=idle 1=travel 2=door.
  int            m_floor = 0, m_timer = 0, m_mode = 0, m_dirn = 0, m_pref = 0;
  logic [NF-1:0] m_pend = '0, m_np;
  logic          m_arrive = 1'b0;
  bit            m_was_mv, m_was_dr;
  snap_t         m_snap;

  function automatic bit any_dir(input logic [NF-1:0] p, input int f, input int d);
    for (int i = 0; i < NF; i++)
      if (p[i] && ((i - f) * d > 0)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cycle++;
    m_was_mv = (m_mode == 1);
    m_was_dr = (m_mode == 2);
    m_arrive = 1'b0;
    if (rst) begin
      m_floor = 0; m_timer = 0; m_mode = 0; m_dirn = 0; m_pend = '0;
    end else begin
      m_np = m_pend | call_req;
      case (m_mode)
        0: begin
          if (m_pend[m_floor]) begin
            m_mode = 2; m_timer = 0; m_np[m_floor] = 1'b0;
          end else if (any_dir(m_pend, m_floor, 1)) begin
            m_mode = 1; m_dirn = 1; m_timer = 0;
          end else if (any_dir(m_pend, m_floor, -1)) begin
            m_mode = 1; m_dirn = -1; m_timer = 0;
          end
        end
        1: begin
          if (m_timer == TC - 1) begin
            m_floor  = m_floor + m_dirn;
            m_arrive = 1'b1;
            m_timer  = 0;
            if (m_pend[m_floor]) begin
              m_mode = 2; m_np[m_floor] = 1'b0;
            end else if (!any_dir(m_pend, m_floor, m_dirn)) begin
              m_mode = 0; m_dirn = 0;
            end
          end else m_timer++;
        end
        default: begin
          m_np[m_floor] = 1'b0;
          if (call_req[m_floor]) m_timer = 0;
          else if (m_timer == DC - 1) begin
            m_timer = 0;
            m_pref  = (m_dirn == 0) ? 1 : m_dirn;
            if (any_dir(m_pend, m_floor, m_pref))       begin m_mode = 1; m_dirn = m_pref;  end
            else if (any_dir(m_pend, m_floor, -m_pref)) begin m_mode = 1; m_dirn = -m_pref; end
            else                                        begin m_mode = 0; m_dirn = 0;       end
          end else m_timer++;
        end
      endcase
      m_pend = m_np;
    end
    if (m_arrive || (m_was_mv != (m_mode == 1)) || (m_was_dr != (m_mode == 2))) begin
      m_snap.cyc    = cycle;
      m_snap.pend   = m_pend;
      m_snap.floor  = m_floor;
      m_snap.dir    = (m_dirn > 0) ? 2'b01 : (m_dirn < 0) ? 2'b10 : 2'b00;
      m_snap.moving = (m_mode == 1);
      m_snap.door   = (m_mode == 2);
      m_snap.arrive = m_arrive;
      exp_q.push_back(m_snap);
    end
  end

  // Monitor: a status event is an arrive pulse or any change of moving/door_open.
  logic  prev_moving = 1'b0, prev_door = 1'b0;
  snap_t s;

  always @(negedge clk) begin
    if (arrive === 1'b1 || moving !== prev_moving || door_open !== prev_door) begin
      n_events++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got arrive=%b moving=%b door=%b floor=%0d, expected no event (cycle %0d)",
                 arrive, moving, door_open, cur_floor, cycle);
      end else begin
        s = exp_q.pop_front();
        check("ev_cycle",   cycle,     s.cyc);
        check("ev_floor",   cur_floor, s.floor);
        check("ev_pending", pending,   s.pend);
        check("ev_dir",     dir,       s.dir);
        check("ev_moving",  moving,    s.moving);
        check("ev_door",    door_open, s.door);
        check("ev_arrive",  arrive,    s.arrive);
      end
    end
    prev_moving = moving;
    prev_door   = door_open;
  end

  task automatic pulse(input logic [NF-1:0] m);
    @(negedge clk);
    call_req = m;
    @(negedge clk);
    call_req = '0;
  endtask

  // what: 0 = fully idle, 1 = door open at top floor, 2 = moving
  task automatic wait_for(input int what, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      case (what)
        0:       done = !moving && !door_open && pending == '0;
        1:       done = door_open && cur_floor == FW'(NF - 1);
        default: done = moving;
      endcase
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles, expected condition %0d", name, budget, what);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all calls asserted: nothing may be captured.
    rst = 1'b1;
    call_req = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_pending", pending,   0);
    check("rst_floor",   cur_floor, 0);
    check("rst_dir",     dir,       0);
    check("rst_moving",  moving,    0);
    check("rst_door",    door_open, 0);
    check("rst_arrive",  arrive,    0);
    rst = 1'b0;
    call_req = '0;
    repeat (10) @(negedge clk);
    check("post_rst_moving",  moving,  0);
    check("post_rst_pending", pending, 0);

    // Single long trip 0 -> 3.
    pulse(4'b1000);
    check("trip_pending_latched", pending, 4'b1000);
    check("trip_not_yet_moving",  moving,  0);
    wait_for(0, 200, "trip_idle");
    check("trip_end_floor", cur_floor, 3);

    // Return to 0, then a call at the current floor.
    pulse(4'b0001);
    wait_for(0, 200, "return_idle");
    check("return_floor", cur_floor, 0);
    pulse(4'b0001);
    wait_for(0, 200, "same_floor_idle");
    check("same_floor_floor", cur_floor, 0);

    // SCAN ordering: stops at 2, 3, then 0.
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    pulse(4'b0100);
    repeat (8) @(negedge clk);
    pulse(4'b0001);
    wait_for(0, 300, "scan_idle");
    check("scan_floor", cur_floor, 0);

    // Tie at floor 1 (up wins), then absorb at the open top-floor door.
    pulse(4'b0010);
    wait_for(0, 200, "to_floor1");
    pulse(4'b1001);
    wait_for(1, 200, "tie_door_at_top");
    repeat (2) @(negedge clk);
    pulse(4'b1000);
    check("absorb_pending", pending[NF-1], 0);
    check("absorb_door",    door_open,     1);
    wait_for(0, 300, "tie_idle");
    check("tie_floor", cur_floor, 0);

    // Reset mid-move after leaving floor 1.
    pulse(4'b0010);
    wait_for(0, 200, "to_floor1_again");
    pulse(4'b1000);
    wait_for(2, 50, "leave_floor1");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_floor",   cur_floor, 0);
    check("midrst_dir",     dir,       0);
    check("midrst_pending", pending,   0);
    check("midrst_moving",  moving,    0);

    // Random calls with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      call_req = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rst      = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    call_req = '0;
    rst      = 1'b0;
    wait_for(0, 600, "random_drain");
    repeat (3) @(negedge clk);
    check("sb_drained",   exp_q.size(),     0);
    check("events_seen",  n_events >= 20,   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
